regfile_param: RTL

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Parameterised register file with two combinational read ports, one write port and a
// re-initialisation sequencer. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              init_req,
  output logic              busy,
  output logic              init_done,
  output logic              fsmState
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } stateE;

  stateE             stateQ, stateD;
  logic [ADDR_W-1:0] idxQ, idxD;
  logic              initDoneQ, initDoneD;
  logic [DATA_W-1:0] regFile [NUM_REGS];
  logic              wrFire;

  // Write handshake: wr_en is the request, wr_ready the acceptance; a write happens only on an
  // edge where both are high. A request seen while wr_ready is low is dropped, never held.
  assign wr_ready  = (stateQ == IDLE);
  assign busy      = (stateQ == INIT);
  assign init_done = initDoneQ;
  assign fsmState  = stateQ;
  assign wrFire    = wr_en && wr_ready && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      idxQ      <= ADDR_W'(1);
      initDoneQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      idxQ      <= idxD;
      initDoneQ <= initDoneD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    idxD      = idxQ;
    initDoneD = 1'b0;
    case (stateQ)
      IDLE: begin
        if (init_req) begin
          stateD = INIT;
          idxD   = ADDR_W'(1);
        end
      end
      INIT: begin
        idxD = idxQ + 1'b1;
        if (idxQ == LAST_IDX) begin
          stateD    = IDLE;
          idxD      = ADDR_W'(1);
          initDoneD = 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Entry 0 is never written (idx starts at 1, address-0 writes are filtered) so it stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= DATA_W'(i);
    end else if (stateQ == INIT) begin
      regFile[idxQ] <= DATA_W'(idxQ);
    end else if (wrFire) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regFile[rs];
    rd_data_b = regFile[rt];
`ifdef REGFILE_BYPASS_EN
    if (wrFire && (wr_addr == rs)) rd_data_a = wr_data;
    if (wrFire && (wr_addr == rt)) rd_data_b = wr_data;
`endif
    if (rs == '0) rd_data_a = '0;
    if (rt == '0) rd_data_b = '0;
  end

endmodule
